fifo_sync_param: RTL

//  Parametrised single-clock FIFO built on an internal DEPTH x DATA_W register-array RAM; the

---
 rtl/fifo_sync_param_if.sv | 42 ++++
 rtl/fifo_sync_param.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param_if.sv
// ---------------------------------------------------------------------------
// fifo_sync_param_if
// Handshake/status bundle for fifo_sync_param.
//   master : the producer/consumer side; drives flush, wr_en, wr_data, rd_en
//            and clr_err, and observes data and status.
//   slave  : the FIFO itself; drives rd_data, rd_valid, the occupancy flags,
//            count and the sticky error flags.
// clk and rst are not part of the bundle; they stay plain module ports.
// ---------------------------------------------------------------------------
interface fifo_sync_param_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output flush, wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
// Parametrised single-clock FIFO on a DEPTH x DATA_W register-array RAM.
// Tracks occupancy in a dedicated counter, produces registered full/empty and
// programmable almost flags, supports a synchronous flush and keeps sticky
// overflow/underflow flags.
//
// Ports
//   clk   in  clock, all state changes on the rising edge
//   rst   in  asynchronous active-high reset
//   bus   slave side of fifo_sync_param_if:
//           flush, wr_en, wr_data, rd_en, clr_err      (requests)
//           rd_data, rd_valid                          (1-cycle read latency)
//           full, empty, almost_full, almost_empty     (registered status)
//           count                                      (occupancy 0..DEPTH)
//           overflow, underflow                        (sticky errors)
// ---------------------------------------------------------------------------
module fifo_sync_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = 60,
  parameter int AE_LEVEL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_sync_param_if.slave     bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  // Storage: no reset, so it maps onto plain memory.
  logic [DATA_W-1:0] ram [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg,  count_next;
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_valid_reg, rd_valid_next;
  logic              full_reg,  full_next;
  logic              empty_reg, empty_next;
  logic              af_reg,    af_next;
  logic              ae_reg,    ae_next;
  logic              ovf_reg,   ovf_next;
  logic              unf_reg,   unf_next;

  logic              wr_acc;
  logic              rd_acc;

  // Acceptance uses the registered flags (pre-edge state). A write into a
  // full FIFO is taken only when a read frees a slot in the same cycle; a
  // read of an empty FIFO is never taken, so there is no write-to-read bypass.
  always_comb begin
    rd_acc = bus.rd_en & ~empty_reg;
    wr_acc = bus.wr_en & (~full_reg | rd_acc);
  end

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    rd_valid_next = 1'b0;
    ovf_next      = ovf_reg;
    unf_next      = unf_reg;

    if (bus.clr_err) begin
      ovf_next = 1'b0;
      unf_next = 1'b0;
    end

    if (bus.flush) begin
      // Flush drops this cycle's requests without flagging them.
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_acc) wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr_next   = rd_ptr_reg + ADDR_W'(1);
        rd_valid_next = 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
      // Setting is applied after clearing so a new error wins over clr_err.
      if (bus.wr_en & ~wr_acc) ovf_next = 1'b1;
      if (bus.rd_en & ~rd_acc) unf_next = 1'b1;
    end

    // Status is derived from the next count so the registered flags always
    // agree with the registered count.
    full_next  = (count_next == DEPTH_C);
    empty_next = (count_next == '0);
    af_next    = (count_next >= AF_C);
    ae_next    = (count_next <= AE_C);
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && wr_acc) begin
      ram[wr_ptr_reg] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      af_reg       <= 1'b0;
      ae_reg       <= 1'b1;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      rd_valid_reg <= rd_valid_next;
      full_reg     <= full_next;
      empty_reg    <= empty_next;
      af_reg       <= af_next;
      ae_reg       <= ae_next;
      ovf_reg      <= ovf_next;
      unf_reg      <= unf_next;
      // rd_data holds its last value unless a read is taken.
      if (!bus.flush && rd_acc) begin
        rd_data_reg <= ram[rd_ptr_reg];
      end
    end
  end

  assign bus.rd_data      = rd_data_reg;
  assign bus.rd_valid     = rd_valid_reg;
  assign bus.full         = full_reg;
  assign bus.empty        = empty_reg;
  assign bus.almost_full  = af_reg;
  assign bus.almost_empty = ae_reg;
  assign bus.count        = count_reg;
  assign bus.overflow     = ovf_reg;
  assign bus.underflow    = unf_reg;

endmodule
